// File: rtl/sc_scbc_upsm.sv
`default_nettype none
// ============================================================================
// Module   : sc_scbc_upsm
// Brief    : USB port state machine; sequences PHY config and port state
//            changes through the UPSI request/acknowledge channel.
// Revision : 1.0 - initial release
// ============================================================================
module sc_scbc_upsm #(
    parameter int CNT_W       = 8,
    parameter int RESET_MS    = 10,
    parameter int DEBOUNCE_MS = 2,
    parameter int RESUME_MS   = 20
) (
    input  logic       ULPICLK,
    input  logic       ULPIRSTB,
    input  logic       CFG_HOST,
    input  logic       CFG_DEVICE,
    input  logic       PRESET_REQ,
    input  logic       PSUSPEND_REQ,
    input  logic       PRESUME_REQ,
    output logic       UPSI_REQ,
    input  logic       UPSI_ACK,
    output logic       UPSI_TYPE,
    output logic [1:0] UPSI_STATE,
    output logic       UPSI_CFG,
    input  logic [1:0] ULPI_CCS,
    input  logic       FT_1MS,
    output logic       UPS_CONNECT,
    output logic       UPS_RESET,
    output logic       UPS_OPERATIONAL,
    output logic       UPS_SUSPEND,
    output logic       UPS_RESUME,
    output logic [3:0] UPS_STATE,
    output logic       UPS_EVENT
);

    // usbPortMode_e encoding carried on UPSI_STATE
    localparam logic [1:0] MODE_TRISTATE  = 2'd0;
    localparam logic [1:0] MODE_HOSTFS    = 2'd1;
    localparam logic [1:0] MODE_HOSTCHIRP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_MS - 1);
    localparam logic [CNT_W-1:0] RES_LAST   = CNT_W'(RESUME_MS - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'((DEBOUNCE_MS > 0) ? DEBOUNCE_MS - 1 : 0);

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_TRANS    = 4'd1,
        ST_UNCONF   = 4'd2,
        ST_DISCON   = 4'd3,
        ST_DEBOUNCE = 4'd4,
        ST_DISABLE  = 4'd5,
        ST_RESET    = 4'd6,
        ST_OPER     = 4'd7,
        ST_SUSPEND  = 4'd8,
        ST_RESUME   = 4'd9
    } state_e;

    state_e           state, state_nxt;
    state_e           dest, dest_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             cfg_flag, dev_mode, conn_prev;
    logic             req_nxt, type_nxt, cfg_nxt;
    logic [1:0]       mode_nxt, disc_mode;
    logic             connect_nxt, reset_nxt, oper_nxt, suspend_nxt, resume_nxt;
    logic             issue, iss_port, iss_cfg, iss_stay, start_reset;
    logic [1:0]       iss_mode;
    state_e           iss_dest;
    logic             unused_ccs;

    assign unused_ccs = ULPI_CCS[1];
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign disc_mode  = dev_mode ? MODE_TRISTATE : MODE_HOSTFS;
    assign UPS_STATE  = state;

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            cfg_flag        <= 1'b0;
            dev_mode        <= 1'b0;
            state           <= ST_OFF;
            dest            <= ST_OFF;
            cnt             <= '0;
            UPSI_REQ        <= 1'b0;
            UPSI_TYPE       <= 1'b0;
            UPSI_STATE      <= MODE_TRISTATE;
            UPSI_CFG        <= 1'b0;
            UPS_CONNECT     <= 1'b0;
            UPS_RESET       <= 1'b0;
            UPS_OPERATIONAL <= 1'b0;
            UPS_SUSPEND     <= 1'b0;
            UPS_RESUME      <= 1'b0;
            conn_prev       <= 1'b0;
            UPS_EVENT       <= 1'b0;
        end else begin
            cfg_flag        <= CFG_HOST ^ CFG_DEVICE;
            dev_mode        <= CFG_DEVICE & ~CFG_HOST;
            state           <= state_nxt;
            dest            <= dest_nxt;
            cnt             <= cnt_nxt;
            UPSI_REQ        <= req_nxt;
            UPSI_TYPE       <= type_nxt;
            UPSI_STATE      <= mode_nxt;
            UPSI_CFG        <= cfg_nxt;
            UPS_CONNECT     <= connect_nxt;
            UPS_RESET       <= reset_nxt;
            UPS_OPERATIONAL <= oper_nxt;
            UPS_SUSPEND     <= suspend_nxt;
            UPS_RESUME      <= resume_nxt;
            conn_prev       <= UPS_CONNECT;
            UPS_EVENT       <= UPS_CONNECT ^ conn_prev;
        end
    end

    always_comb begin
        state_nxt   = state;
        dest_nxt    = dest;
        cnt_nxt     = cnt;
        req_nxt     = UPSI_REQ;
        type_nxt    = UPSI_TYPE;
        mode_nxt    = UPSI_STATE;
        cfg_nxt     = UPSI_CFG;
        connect_nxt = UPS_CONNECT;
        reset_nxt   = UPS_RESET;
        oper_nxt    = UPS_OPERATIONAL;
        suspend_nxt = UPS_SUSPEND;
        resume_nxt  = UPS_RESUME;
        issue       = 1'b0;
        iss_port    = 1'b0;
        iss_mode    = MODE_TRISTATE;
        iss_cfg     = 1'b0;
        iss_dest    = ST_OFF;
        iss_stay    = 1'b0;
        start_reset = 1'b0;

        case (state)
            ST_OFF: begin
                issue    = 1'b1;
                iss_port = 1'b1;
                iss_mode = MODE_TRISTATE;
                iss_dest = ST_UNCONF;
            end
            ST_TRANS: begin
                if (UPSI_REQ && UPSI_ACK) begin
                    req_nxt   = 1'b0;
                    state_nxt = dest;
                end
            end
            ST_UNCONF: begin
                // The config request is issued from here directly; its ack
                // chains straight into the port-state request.
                if (UPSI_REQ && UPSI_ACK) begin
                    issue    = 1'b1;
                    iss_port = 1'b1;
                    iss_mode = disc_mode;
                    iss_dest = ST_DISCON;
                end else if (cfg_flag && !UPSI_REQ) begin
                    issue    = 1'b1;
                    iss_cfg  = dev_mode;
                    iss_stay = 1'b1;
                end
            end
            default: begin
                if (!cfg_flag) begin
                    connect_nxt = 1'b0;
                    reset_nxt   = 1'b0;
                    oper_nxt    = 1'b0;
                    suspend_nxt = 1'b0;
                    resume_nxt  = 1'b0;
                    issue       = 1'b1;
                    iss_cfg     = 1'b1;
                    iss_dest    = ST_OFF;
                end else if (!ULPI_CCS[0] && state != ST_DISCON) begin
                    if (state == ST_DEBOUNCE) begin
                        state_nxt = ST_DISCON;
                    end else begin
                        connect_nxt = 1'b0;
                        reset_nxt   = 1'b0;
                        oper_nxt    = 1'b0;
                        suspend_nxt = 1'b0;
                        resume_nxt  = 1'b0;
                        issue       = 1'b1;
                        iss_port    = 1'b1;
                        iss_mode    = disc_mode;
                        iss_dest    = ST_DISCON;
                    end
                end else begin
                    case (state)
                        ST_DISCON: begin
                            if (ULPI_CCS[0]) begin
                                if (DEBOUNCE_MS == 0) begin
                                    state_nxt   = ST_DISABLE;
                                    connect_nxt = 1'b1;
                                end else begin
                                    cnt_nxt   = '0;
                                    state_nxt = ST_DEBOUNCE;
                                end
                            end
                        end
                        ST_DEBOUNCE: begin
                            if (FT_1MS) begin
                                if (cnt == DEB_LAST) begin
                                    state_nxt   = ST_DISABLE;
                                    connect_nxt = 1'b1;
                                end else begin
                                    cnt_nxt = cnt_inc;
                                end
                            end
                        end
                        ST_DISABLE: begin
                            if (!dev_mode && PRESET_REQ) begin
                                start_reset = 1'b1;
                            end
                        end
                        ST_RESET: begin
                            if (FT_1MS) begin
                                if (cnt == RESET_LAST) begin
                                    reset_nxt = 1'b0;
                                    oper_nxt  = 1'b1;
                                    issue     = 1'b1;
                                    iss_port  = 1'b1;
                                    iss_mode  = MODE_HOSTFS;
                                    iss_dest  = ST_OPER;
                                end else begin
                                    cnt_nxt = cnt_inc;
                                end
                            end
                        end
                        ST_OPER: begin
                            if (!dev_mode && PRESET_REQ) begin
                                oper_nxt    = 1'b0;
                                start_reset = 1'b1;
                            end else if (!dev_mode && PSUSPEND_REQ) begin
                                oper_nxt    = 1'b0;
                                suspend_nxt = 1'b1;
                                state_nxt   = ST_SUSPEND;
                            end
                        end
                        ST_SUSPEND: begin
                            if (!dev_mode && PRESET_REQ) begin
                                suspend_nxt = 1'b0;
                                start_reset = 1'b1;
                            end else if (!dev_mode && PRESUME_REQ) begin
                                resume_nxt = 1'b1;
                                cnt_nxt    = '0;
                                issue      = 1'b1;
                                iss_port   = 1'b1;
                                iss_mode   = MODE_HOSTCHIRP;
                                iss_dest   = ST_RESUME;
                            end
                        end
                        ST_RESUME: begin
                            if (FT_1MS) begin
                                if (cnt == RES_LAST) begin
                                    resume_nxt  = 1'b0;
                                    suspend_nxt = 1'b0;
                                    oper_nxt    = 1'b1;
                                    issue       = 1'b1;
                                    iss_port    = 1'b1;
                                    iss_mode    = MODE_HOSTFS;
                                    iss_dest    = ST_OPER;
                                end else begin
                                    cnt_nxt = cnt_inc;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase

        if (start_reset) begin
            reset_nxt = 1'b1;
            cnt_nxt   = '0;
            issue     = 1'b1;
            iss_port  = 1'b1;
            iss_mode  = MODE_HOSTCHIRP;
            iss_dest  = ST_RESET;
        end

        // Only the field matching the request type is reloaded.
        if (issue) begin
            req_nxt  = 1'b1;
            type_nxt = iss_port;
            if (iss_port) begin
                mode_nxt = iss_mode;
            end else begin
                cfg_nxt = iss_cfg;
            end
            if (!iss_stay) begin
                state_nxt = ST_TRANS;
                dest_nxt  = iss_dest;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_scbc_upsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_scbc_upsm
// Brief    : Scoreboard bench for sc_scbc_upsm request sequencing and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_scbc_upsm;

    localparam logic [1:0] M_TRI   = 2'd0;
    localparam logic [1:0] M_HFS   = 2'd1;
    localparam logic [1:0] M_CHIRP = 2'd2;

    logic       ULPICLK = 1'b0;
    logic       ULPIRSTB;
    logic       CFG_HOST, CFG_DEVICE;
    logic       PRESET_REQ, PSUSPEND_REQ, PRESUME_REQ;
    logic       UPSI_REQ, UPSI_ACK, UPSI_TYPE, UPSI_CFG;
    logic [1:0] UPSI_STATE;
    logic [1:0] ULPI_CCS;
    logic       FT_1MS;
    logic       UPS_CONNECT, UPS_RESET, UPS_OPERATIONAL, UPS_SUSPEND, UPS_RESUME;
    logic [3:0] UPS_STATE;
    logic       UPS_EVENT;

    int   checks   = 0;
    int   errors   = 0;
    int   hs_count = 0;
    int   ev_count = 0;
    bit   ack_en   = 1'b0;
    logic [2:0] sb[$];

    sc_scbc_upsm #(
        .CNT_W(8), .RESET_MS(10), .DEBOUNCE_MS(2), .RESUME_MS(20)
    ) dut (
        .ULPICLK(ULPICLK), .ULPIRSTB(ULPIRSTB),
        .CFG_HOST(CFG_HOST), .CFG_DEVICE(CFG_DEVICE),
        .PRESET_REQ(PRESET_REQ), .PSUSPEND_REQ(PSUSPEND_REQ), .PRESUME_REQ(PRESUME_REQ),
        .UPSI_REQ(UPSI_REQ), .UPSI_ACK(UPSI_ACK), .UPSI_TYPE(UPSI_TYPE),
        .UPSI_STATE(UPSI_STATE), .UPSI_CFG(UPSI_CFG),
        .ULPI_CCS(ULPI_CCS), .FT_1MS(FT_1MS),
        .UPS_CONNECT(UPS_CONNECT), .UPS_RESET(UPS_RESET),
        .UPS_OPERATIONAL(UPS_OPERATIONAL), .UPS_SUSPEND(UPS_SUSPEND),
        .UPS_RESUME(UPS_RESUME), .UPS_STATE(UPS_STATE), .UPS_EVENT(UPS_EVENT)
    );

    always #5 ULPICLK = ~ULPICLK;

    function automatic logic [2:0] st_req(input logic [1:0] m);
        return {1'b1, m};
    endfunction

    function automatic logic [2:0] cfg_req(input logic c);
        return {2'b00, c};
    endfunction

    // PHY responder: acks one cycle after REQ and checks each accepted request
    initial begin
        logic [2:0] got, exp;
        UPSI_ACK = 1'b0;
        forever begin
            @(negedge ULPICLK);
            if (ack_en && UPSI_REQ === 1'b1 && !UPSI_ACK) begin
                got = UPSI_TYPE ? {1'b1, UPSI_STATE} : {2'b00, UPSI_CFG};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL upsi_req_unexpected: got %b, expected no request", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL upsi_req_fields: got %b, expected %b", got, exp);
                    end
                end
                hs_count++;
                UPSI_ACK = 1'b1;
            end else begin
                UPSI_ACK = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge ULPICLK);
            if (UPS_EVENT === 1'b1) ev_count++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic ft_tick();
        FT_1MS = 1'b1;
        @(negedge ULPICLK);
        FT_1MS = 1'b0;
        @(negedge ULPICLK);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ULPICLK);
            if (UPS_STATE === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [14:0] snap;
        bit ok;
        ULPIRSTB = 1'b0; CFG_HOST = 1'b1; CFG_DEVICE = 1'b0;
        PRESET_REQ = 1'b0; PSUSPEND_REQ = 1'b0; PRESUME_REQ = 1'b0;
        ULPI_CCS = 2'b00; FT_1MS = 1'b0; ack_en = 1'b1;
        repeat (3) @(negedge ULPICLK);
        snap = {UPSI_REQ, UPSI_TYPE, UPSI_STATE, UPSI_CFG, UPS_CONNECT, UPS_RESET,
                UPS_OPERATIONAL, UPS_SUSPEND, UPS_RESUME, UPS_EVENT, UPS_STATE};
        checks++;
        if (snap !== 15'd0) begin
            errors++; $display("FAIL reset_values: got %b, expected %b", snap, 15'd0);
        end
        sb.push_back(st_req(M_TRI));
        sb.push_back(cfg_req(1'b0));
        sb.push_back(st_req(M_HFS));
        ULPIRSTB = 1'b1;
        @(negedge ULPICLK);
        checks++;
        if (UPSI_REQ !== 1'b1) begin
            errors++; $display("FAIL req_after_reset: got %b, expected 1", UPSI_REQ);
        end
        wait_state(4'd3, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL powerup_discon: UPS_STATE got %0d, expected 3", UPS_STATE);
        end
        checks++;
        if (sb.size() != 0 || UPSI_REQ !== 1'b0) begin
            errors++; $display("FAIL powerup_requests: pending %0d req %b, expected 0 and 0", sb.size(), UPSI_REQ);
        end
    endtask

    task automatic test_debounce();
        int hs0;
        hs0 = hs_count;
        ULPI_CCS = 2'b01;
        @(negedge ULPICLK);
        checks++;
        if (UPS_STATE !== 4'd4) begin
            errors++; $display("FAIL debounce_entry: got %0d, expected 4", UPS_STATE);
        end
        ft_tick();
        ULPI_CCS = 2'b00;
        @(negedge ULPICLK);
        checks++;
        if (UPS_STATE !== 4'd3 || UPS_CONNECT !== 1'b0 || hs_count != hs0) begin
            errors++; $display("FAIL debounce_abort: state %0d connect %b handshakes %0d, expected 3 0 %0d",
                               UPS_STATE, UPS_CONNECT, hs_count, hs0);
        end
        ULPI_CCS = 2'b01;
        @(negedge ULPICLK);
        ft_tick();
        checks++;
        if (UPS_STATE !== 4'd4 || UPS_CONNECT !== 1'b0) begin
            errors++; $display("FAIL debounce_one_tick: state %0d connect %b, expected 4 0", UPS_STATE, UPS_CONNECT);
        end
        FT_1MS = 1'b1;
        @(negedge ULPICLK);
        FT_1MS = 1'b0;
        checks++;
        if (UPS_STATE !== 4'd5 || UPS_CONNECT !== 1'b1 || UPS_EVENT !== 1'b0) begin
            errors++; $display("FAIL debounce_done: state %0d connect %b event %b, expected 5 1 0",
                               UPS_STATE, UPS_CONNECT, UPS_EVENT);
        end
        @(negedge ULPICLK);
        checks++;
        if (UPS_EVENT !== 1'b1) begin
            errors++; $display("FAIL connect_event: got %b, expected 1", UPS_EVENT);
        end
        @(negedge ULPICLK);
        checks++;
        if (UPS_EVENT !== 1'b0) begin
            errors++; $display("FAIL connect_event_width: got %b, expected 0", UPS_EVENT);
        end
    endtask

    task automatic test_port_reset();
        bit ok;
        ack_en = 1'b0;
        sb.push_back(st_req(M_CHIRP));
        PRESET_REQ = 1'b1;
        @(negedge ULPICLK);
        PRESET_REQ = 1'b0;
        repeat (3) ft_tick();
        checks++;
        if (UPS_STATE !== 4'd1 || UPSI_REQ !== 1'b1 || UPS_RESET !== 1'b1) begin
            errors++; $display("FAIL reset_trans_hold: state %0d req %b reset %b, expected 1 1 1",
                               UPS_STATE, UPSI_REQ, UPS_RESET);
        end
        ack_en = 1'b1;
        wait_state(4'd6, 10, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL reset_entry: got %0d, expected 6", UPS_STATE);
        end
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) sb.push_back(st_req(M_HFS));
            ft_tick();
            checks++;
            if (i < 10) begin
                if (UPS_RESET !== 1'b1 || UPS_STATE !== 4'd6) begin
                    errors++; $display("FAIL reset_duration tick %0d: reset %b state %0d, expected 1 6",
                                       i, UPS_RESET, UPS_STATE);
                end
            end else if (UPS_RESET !== 1'b0 || UPS_OPERATIONAL !== 1'b1) begin
                errors++; $display("FAIL reset_end: reset %b oper %b, expected 0 1", UPS_RESET, UPS_OPERATIONAL);
            end
        end
        wait_state(4'd7, 10, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++; $display("FAIL reset_to_oper: state %0d pending %0d, expected 7 0", UPS_STATE, sb.size());
        end
    endtask

    task automatic test_suspend_resume();
        bit ok;
        int hs0;
        hs0 = hs_count;
        PSUSPEND_REQ = 1'b1;
        @(negedge ULPICLK);
        PSUSPEND_REQ = 1'b0;
        checks++;
        if (UPS_STATE !== 4'd8 || UPS_SUSPEND !== 1'b1 || UPS_OPERATIONAL !== 1'b0 || UPSI_REQ !== 1'b0) begin
            errors++; $display("FAIL suspend: state %0d susp %b oper %b req %b, expected 8 1 0 0",
                               UPS_STATE, UPS_SUSPEND, UPS_OPERATIONAL, UPSI_REQ);
        end
        @(negedge ULPICLK);
        checks++;
        if (hs_count != hs0) begin
            errors++; $display("FAIL suspend_no_request: handshakes %0d, expected %0d", hs_count, hs0);
        end
        sb.push_back(st_req(M_CHIRP));
        PRESUME_REQ = 1'b1;
        @(negedge ULPICLK);
        PRESUME_REQ = 1'b0;
        checks++;
        if (UPS_RESUME !== 1'b1 || UPS_STATE !== 4'd1) begin
            errors++; $display("FAIL resume_start: resume %b state %0d, expected 1 1", UPS_RESUME, UPS_STATE);
        end
        wait_state(4'd9, 10, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL resume_entry: got %0d, expected 9", UPS_STATE);
        end
        for (int i = 1; i <= 20; i++) begin
            if (i == 20) sb.push_back(st_req(M_HFS));
            ft_tick();
            checks++;
            if (i < 20) begin
                if (UPS_RESUME !== 1'b1 || UPS_STATE !== 4'd9) begin
                    errors++; $display("FAIL resume_duration tick %0d: resume %b state %0d, expected 1 9",
                                       i, UPS_RESUME, UPS_STATE);
                end
            end else if (UPS_RESUME !== 1'b0 || UPS_SUSPEND !== 1'b0 || UPS_OPERATIONAL !== 1'b1) begin
                errors++; $display("FAIL resume_end: resume %b susp %b oper %b, expected 0 0 1",
                                   UPS_RESUME, UPS_SUSPEND, UPS_OPERATIONAL);
            end
        end
        wait_state(4'd7, 10, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++; $display("FAIL resume_to_oper: state %0d pending %0d, expected 7 0", UPS_STATE, sb.size());
        end
    endtask

    task automatic test_deferred_disconnect();
        logic [3:0] fields;
        bit ok;
        int ev0;
        ack_en = 1'b0;
        sb.push_back(st_req(M_CHIRP));
        PRESET_REQ = 1'b1;
        @(negedge ULPICLK);
        PRESET_REQ = 1'b0;
        fields = {UPSI_TYPE, UPSI_STATE, UPSI_CFG};
        ULPI_CCS = 2'b00;
        repeat (3) @(negedge ULPICLK);
        checks++;
        if ({UPSI_TYPE, UPSI_STATE, UPSI_CFG} !== fields || fields !== {1'b1, M_CHIRP, 1'b0} ||
            UPSI_REQ !== 1'b1 || UPS_STATE !== 4'd1) begin
            errors++; $display("FAIL trans_fields_stable: fields %b req %b state %0d, expected %b 1 1",
                               {UPSI_TYPE, UPSI_STATE, UPSI_CFG}, UPSI_REQ, UPS_STATE, {1'b1, M_CHIRP, 1'b0});
        end
        ev0 = ev_count;
        sb.push_back(st_req(M_HFS));
        ack_en = 1'b1;
        wait_state(4'd3, 20, ok);
        checks++;
        if (!ok || UPS_CONNECT !== 1'b0 || UPS_RESET !== 1'b0) begin
            errors++; $display("FAIL deferred_disconnect: state %0d connect %b reset %b, expected 3 0 0",
                               UPS_STATE, UPS_CONNECT, UPS_RESET);
        end
        repeat (2) @(negedge ULPICLK);
        checks++;
        if (sb.size() != 0 || ev_count != ev0 + 1) begin
            errors++; $display("FAIL disconnect_event: pending %0d events %0d, expected 0 %0d",
                               sb.size(), ev_count - ev0, 1);
        end
    endtask

    task automatic test_unconfigure();
        bit ok1, ok2, ok3;
        ULPI_CCS = 2'b01;
        @(negedge ULPICLK);
        ft_tick();
        ft_tick();
        wait_state(4'd5, 10, ok1);
        sb.push_back(st_req(M_CHIRP));
        PRESET_REQ = 1'b1;
        @(negedge ULPICLK);
        PRESET_REQ = 1'b0;
        wait_state(4'd6, 10, ok2);
        repeat (9) ft_tick();
        sb.push_back(st_req(M_HFS));
        ft_tick();
        wait_state(4'd7, 10, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3)) begin
            errors++; $display("FAIL reconnect_to_oper: reached %b%b%b, expected 111", ok1, ok2, ok3);
        end
        sb.push_back(cfg_req(1'b1));
        sb.push_back(st_req(M_TRI));
        CFG_DEVICE = 1'b1;
        @(negedge ULPICLK);
        checks++;
        if (UPS_STATE !== 4'd7 || UPS_OPERATIONAL !== 1'b1) begin
            errors++; $display("FAIL cfg_flag_latency: state %0d oper %b, expected 7 1", UPS_STATE, UPS_OPERATIONAL);
        end
        @(negedge ULPICLK);
        checks++;
        if ({UPS_CONNECT, UPS_RESET, UPS_OPERATIONAL, UPS_SUSPEND, UPS_RESUME} !== 5'd0 ||
            UPS_STATE !== 4'd1 || {UPSI_REQ, UPSI_TYPE, UPSI_CFG} !== 3'b101) begin
            errors++; $display("FAIL unconfigure: ups %b state %0d req/type/cfg %b, expected 00000 1 101",
                               {UPS_CONNECT, UPS_RESET, UPS_OPERATIONAL, UPS_SUSPEND, UPS_RESUME},
                               UPS_STATE, {UPSI_REQ, UPSI_TYPE, UPSI_CFG});
        end
        wait_state(4'd0, 10, ok1);
        wait_state(4'd2, 10, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++; $display("FAIL unconf_path: off %b unconf %b, expected 1 1", ok1, ok2);
        end
        repeat (4) @(negedge ULPICLK);
        checks++;
        if (UPSI_REQ !== 1'b0 || UPS_STATE !== 4'd2 || sb.size() != 0) begin
            errors++; $display("FAIL unconf_idle: req %b state %0d pending %0d, expected 0 2 0",
                               UPSI_REQ, UPS_STATE, sb.size());
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        ack_en = 1'b0;
        CFG_DEVICE = 1'b0;
        repeat (4) @(negedge ULPICLK);
        checks++;
        if ({UPSI_REQ, UPSI_TYPE, UPSI_CFG} !== 3'b100 || UPS_STATE !== 4'd2) begin
            errors++; $display("FAIL unconf_cfg_request: req/type/cfg %b state %0d, expected 100 2",
                               {UPSI_REQ, UPSI_TYPE, UPSI_CFG}, UPS_STATE);
        end
        #2;
        ULPIRSTB = 1'b0;
        #1;
        checks++;
        if (UPSI_REQ !== 1'b0 || UPS_STATE !== 4'd0) begin
            errors++; $display("FAIL async_reset: req %b state %0d, expected 0 0", UPSI_REQ, UPS_STATE);
        end
        sb.delete();
        @(negedge ULPICLK);
        sb.push_back(st_req(M_TRI));
        sb.push_back(cfg_req(1'b0));
        sb.push_back(st_req(M_HFS));
        ack_en = 1'b1;
        ULPIRSTB = 1'b1;
        wait_state(4'd3, 40, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++; $display("FAIL restart_after_reset: state %0d pending %0d, expected 3 0", UPS_STATE, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_port_reset();
        test_suspend_resume();
        test_deferred_disconnect();
        test_unconfigure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
